// File: rtl/hex_display_scan_if.sv
// Display-side bundle for hex_display_scan: register-mapped inputs
// and the segment/digit pin outputs.
interface hex_display_scan_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    enable;
    logic [BRIGHT_W-1:0]     brightness;
    logic [6:0]              segment;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   omask;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output value, dp, load, enable, brightness,
        input  segment, dp_out, omask, frame_start, pending
    );

    modport slave (
        input  value, dp, load, enable, brightness,
        output segment, dp_out, omask, frame_start, pending
    );
endinterface

// File: rtl/hex_display_scan.sv
// N-digit multiplexed 7-seg hex driver: double-buffered load, PWM, ghost guard.
// Define HEXDISP_LZB_EN to enable leading-zero blanking.
module hex_display_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_W     = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    hex_display_scan_if.slave bus
);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {PH_GUARD, PH_ON, PH_OFF} phase_e;

    logic [SLOT_W-1:0]          cnt_q, cnt_d;
    logic [DIG_W-1:0]           dig_q, dig_d;
    logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]      disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic                       pending_q, pending_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0]      omask_q, omask_d;
    logic                       fs_q, fs_d;

    logic [BRIGHT_W-1:0] sub;
    logic                slot_end;
    logic                boundary;
    logic                lead_zero;
    logic [3:0]          nib;
    phase_e              phase;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

    assign sub      = cnt_q[SLOT_W-1 -: BRIGHT_W];
    assign slot_end = &cnt_q;
    assign boundary = slot_end && (dig_q == DIG_LAST);
    assign nib      = disp_q[dig_q];

    // Subslice 0 is always dark so the previous digit's select can settle.
    always_comb begin
        phase = PH_OFF;
        unique case (1'b1)
            (sub == '0):
                phase = PH_GUARD;
            (sub != '0 && sub <= bus.brightness):
                phase = PH_ON;
            (sub > bus.brightness):
                phase = PH_OFF;
            default:
                phase = PH_OFF;
        endcase
    end

`ifdef HEXDISP_LZB_EN
    logic [NUM_DIGITS-1:0] lz;

    // lz[i]: digit i and everything above it are zero with no dp set.
    always_comb begin : lzb
        logic z;
        z  = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z     = z & (disp_q[i] == 4'h0) & ~disp_dp_q[i];
            lz[i] = z;
        end
        lead_zero = (dig_q != '0) && lz[dig_q];
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        dig_d       = dig_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        seg_d       = '0;
        dpo_d       = 1'b0;
        omask_d     = '1;
        fs_d        = (dig_q == '0) && (cnt_q == '0);

        if (slot_end) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end

        // A load on the boundary bypasses the shadow stage.
        if (bus.load && boundary) begin
            disp_d      = bus.value;
            disp_dp_d   = bus.dp;
            shadow_d    = bus.value;
            shadow_dp_d = bus.dp;
            pending_d   = 1'b0;
        end else if (bus.load) begin
            shadow_d    = bus.value;
            shadow_dp_d = bus.dp;
            pending_d   = 1'b1;
        end else if (boundary && pending_q) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end

        if (bus.enable && phase == PH_ON && !lead_zero) begin
            omask_d = ~(NUM_DIGITS'(1) << dig_q);
            seg_d   = glyph(nib);
            dpo_d   = disp_dp_q[dig_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            dig_q       <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            seg_q       <= '0;
            dpo_q       <= 1'b0;
            omask_q     <= '1;
            fs_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dpo_q       <= dpo_d;
            omask_q     <= omask_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.segment     = seg_q;
    assign bus.dp_out      = dpo_q;
    assign bus.omask       = omask_q;
    assign bus.frame_start = fs_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (4 digits, 16-cycle slots, 2-bit PWM).
// Honours HEXDISP_LZB_EN when the design is built with it.
module tb_hex_display_scan;
    localparam int N  = 4;
    localparam int SW = 4;
    localparam int BW = 2;
`ifdef HEXDISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   exp_pend;

    hex_display_scan_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

    hex_display_scan #(
        .NUM_DIGITS(N),
        .SLOT_W    (SW),
        .BRIGHT_W  (BW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_seg"},   32'(bus.segment),     32'h0);
        chk({tag, "_dpo"},   32'(bus.dp_out),      32'h0);
        chk({tag, "_omask"}, 32'(bus.omask),       32'hF);
        chk({tag, "_fs"},    32'(bus.frame_start), 32'h0);
        chk({tag, "_pend"},  32'(bus.pending),     32'h0);
    endtask

    // One 64-cycle frame; g = {g3,g2,g1,g0} glyphs held in disp this frame.
    task automatic frame(input logic [31:0] g,
                         input logic [3:0]  dpv,
                         input logic [3:0]  blk,
                         input int          br,
                         input bit          en,
                         input int          la1,
                         input logic [15:0] lv1,
                         input logic [3:0]  ld1,
                         input int          la2,
                         input logic [15:0] lv2,
                         input logic [3:0]  ld2);
        int         d;
        int         s;
        bit         lit;
        logic [3:0] em;
        logic [6:0] eg;
        bus.brightness = BW'(br);
        bus.enable     = en;
        for (int j = 0; j < 64; j++) begin
            bus.load = 1'b0;
            if (j == la1) begin
                bus.value = lv1;
                bus.dp    = ld1;
                bus.load  = 1'b1;
            end
            if (j == la2) begin
                bus.value = lv2;
                bus.dp    = ld2;
                bus.load  = 1'b1;
            end
            tick();
            if (bus.load) exp_pend = (j != 63);
            else if (j == 63) exp_pend = 1'b0;
            d   = j / 16;
            s   = (j % 16) / 4;
            lit = en && s != 0 && s <= br && !blk[d];
            em  = lit ? ~(4'b0001 << d) : 4'hF;
            eg  = lit ? g[8*d +: 7] : 7'h0;
            chk("omask", 32'(bus.omask),       32'(em));
            chk("seg",   32'(bus.segment),     32'(eg));
            chk("dpo",   32'(bus.dp_out),      32'(lit && dpv[d]));
            chk("fs",    32'(bus.frame_start), 32'(j == 0));
            chk("pend",  32'(bus.pending),     32'(exp_pend));
        end
        bus.load = 1'b0;
    endtask

    initial begin
        bus.value      = '0;
        bus.dp         = '0;
        bus.load       = 1'b0;
        bus.enable     = 1'b1;
        bus.brightness = BW'(3);
        exp_pend       = 1'b0;
        repeat (3) tick();
        chk_reset_outs("rst");
        reset_n = 1'b1;

        // disp=0; load 12AF early in the frame
        frame(32'h3F3F3F3F, 4'h0, LZB ? 4'hE : 4'h0, 3, 1'b1,
              1, 16'h12AF, 4'h0, -1, 16'h0, 4'h0);
        // 12AF shown; mid-frame load of 0001 waits for the boundary
        frame(32'h065B7771, 4'h0, 4'h0, 3, 1'b1,
              20, 16'h0001, 4'h0, -1, 16'h0, 4'h0);
        // 0001 at brightness 1; two loads, last one wins
        frame(32'h3F3F3F06, 4'h0, LZB ? 4'hE : 4'h0, 1, 1'b1,
              10, 16'h1111, 4'h0, 40, 16'h2222, 4'h0);
        // 2222 shown; load lands exactly on the boundary
        frame(32'h5B5B5B5B, 4'h0, 4'h0, 1, 1'b1,
              63, 16'h00A5, 4'b0100, -1, 16'h0, 4'h0);
        // brightness 0 is dark
        frame(32'h3F3F776D, 4'b0100, LZB ? 4'h8 : 4'h0, 0, 1'b1,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // enable low blanks while frame_start keeps pulsing
        frame(32'h3F3F776D, 4'b0100, LZB ? 4'h8 : 4'h0, 3, 1'b0,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // brightness 2 with decimal point on digit 2
        frame(32'h3F3F776D, 4'b0100, LZB ? 4'h8 : 4'h0, 2, 1'b1,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        bus.value = 16'hBEEF;
        bus.dp    = 4'hF;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        chk("pre_rst_pend", 32'(bus.pending), 32'h1);
        repeat (4) tick();
        chk("pre_rst_omask", 32'(bus.omask), 32'hE);
        reset_n = 1'b0;
        #2;
        chk_reset_outs("async_rst");
        exp_pend = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;

        // shadow and disp were cleared by reset
        frame(32'h3F3F3F3F, 4'h0, LZB ? 4'hE : 4'h0, 3, 1'b1,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Parametrised, time-multiplexed common-cathode 7-segment hex display driver for N digits, with a double-buffered value load, per-digit decimal points, PWM brightness and an inter-digit ghosting guard. It sits between register-mapped display data and the board's segment/digit pins. Segment outputs are active high and digit selects are active low. It is the multi-digit, dimmable successor to the fixed 4-digit scanner.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SLOT_W, 16: each digit slot lasts 2^SLOT_W cycles; requires SLOT_W > BRIGHT_W.
- BRIGHT_W, 4: width of the brightness control.
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i], and digit 0 is the rightmost.
- dp  in  NUM_DIGITS  decimal-point request per digit.
- load  in  1  single-cycle strobe that captures value and dp.
- enable  in  1  when 0, all outputs are blanked while scanning continues.
- brightness  in  BRIGHT_W  on-time in subslices; 0 means dark.
- segment  out  7  {g,f,e,d,c,b,a}, active high.
- dp_out  out  1  decimal-point segment, active high.
- omask  out  NUM_DIGITS  digit select, active low, one-cold.
- frame_start  out  1  one-cycle pulse marking the first cycle of digit 0's slot.
- pending  out  1  a loaded value is waiting for the next frame boundary.

## Operation
- Free-running slot counter cnt (SLOT_W bits) and digit index dig.
  - dig advances when cnt wraps from all-ones to 0.
  - dig wraps from NUM_DIGITS-1 to 0.
- Subslice index sub = cnt[SLOT_W-1 : SLOT_W-BRIGHT_W]. This gives 2^BRIGHT_W subslices per slot.
- Per-slot phases:
  - GUARD (sub==0): omask all ones, segment 0, dp_out 0.
  - ON (1 <= sub <= brightness): omask bit dig low; segment shows the glyph of disp[dig]; dp_out = disp_dp[dig].
  - OFF (sub > brightness): blank, identical to GUARD.
- Brightness is sampled every cycle. Maximum brightness (all ones) lights every subslice except GUARD.
- Glyphs, hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Double buffer:
  - A load pulse writes value/dp into the shadow register and sets pending.
  - At the frame boundary (cycle where dig==NUM_DIGITS-1 and cnt is all ones), if pending is set: disp <= shadow and pending clears.
  - If load coincides with the frame boundary, the new value/dp is written straight into disp and pending stays 0.
  - A second load before the boundary overwrites the shadow register; last write wins.
- enable=0 forces GUARD-style blanking. Counters, frame_start and loads are unaffected.
- Reset mid-frame is immediate:
  - all outputs go to their reset values;
  - the shadow register and disp clear to 0;
  - pending clears;
  - scanning restarts at dig 0, cnt 0.

## Timing
- All outputs are registered. Outputs after edge k reflect the (dig, cnt, disp, enable, brightness) state present before edge k, i.e. one cycle of latency.
- Reset values: segment 0, dp_out 0, omask all ones, frame_start 0, pending 0, cnt 0, dig 0, disp 0, shadow 0.
- After reset release:
  - the first edge sets frame_start=1 (state 0,0) with blank outputs (GUARD);
  - frame_start then recurs every NUM_DIGITS*2^SLOT_W cycles.
- pending rises on the edge that samples load=1. It falls on the frame-boundary edge. New digits appear on outputs at the first ON cycle of digit 0's next slot.
- Frame period is NUM_DIGITS*2^SLOT_W cycles; at the 50 MHz, 4-digit default this is ≈5.2 ms.

## Configuration
- HEXDISP_LZB_EN defined: leading-zero blanking.
  - In ON phase, digit i > 0 is blanked (omask all ones, segment 0) if disp[i] and all higher digits are 0 and none of disp_dp[i..NUM_DIGITS-1] is set.
  - Digit 0 is never blanked.
  - GUARD timing and frame_start are unchanged.
- Undefined: every digit is displayed, including leading zeros.

## Test plan
- Use NUM_DIGITS=4, SLOT_W=4, BRIGHT_W=2 throughout.
- Reset release, load value=16'h12AF, brightness=3: after the boundary, digit 0's slot shows cycles 0-3 blank, then 12 cycles of omask=1110, segment=0x71. Digits 1/2/3 show 0x77/0x5B/0x06 with omask 1101/1011/0111.
- brightness=1: each slot gives 4 blank, 4 lit, 8 blank cycles. brightness=0: omask stays 1111 for a full frame.
- Load 16'h0001 mid-frame: pending=1 until the boundary. Digits keep showing the old disp until the boundary, then switch. A load exactly on the boundary cycle updates disp with pending staying 0.
- Two loads (16'h1111 then 16'h2222) in one frame: only 2222 is ever displayed.
- enable=0 for one frame: omask 1111 and segment 0 throughout, while frame_start still pulses every 64 cycles. Assert reset_n=0 mid-slot: outputs are at reset values within the same cycle with no clock.
- With HEXDISP_LZB_EN, value=16'h0050, dp=0: digits 3 and 2 stay dark, digit 1=0x6D, digit 0=0x3F. Setting dp=4'b1000 re-enables digits 3 and 2, showing 0x3F with dp_out=1 on digit 3.
